// File: rtl/o_feature_store.sv
// o_feature_store: streams lines from an on-chip output feature bank to consecutive external addresses.
// The output register plus one skid entry absorb sink backpressure without losing returning read data.
module o_feature_store #(
    parameter int DATA_BUS_WIDTH = 128,
    parameter int EXT_ADDR_WIDTH = 16,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      store_enable,
    input  logic [MEM_ADDR_WIDTH-1:0] src_addr,
    input  logic [EXT_ADDR_WIDTH-1:0] dst_addr,
    input  logic                      mem_sel,
    input  logic [COUNT_WIDTH-1:0]    store_count,
    output logic                      busy,
    output logic                      store_done,
    output logic                      mem_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                      mem_rd_sel,
    input  logic [DATA_BUS_WIDTH-1:0] mem_rd_data,
    output logic [DATA_BUS_WIDTH-1:0] o_data_bus_port,
    output logic [EXT_ADDR_WIDTH-1:0] o_feature_addr,
    output logic                      o_feature_wr_en,
    input  logic                      o_bus_ready
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] rd_addr_q;
    logic                      sel_q;
    logic [COUNT_WIDTH-1:0]    rd_left_q, wr_left_q;
    logic [EXT_ADDR_WIDTH-1:0] addr_q, next_addr_q;
    logic [DATA_BUS_WIDTH-1:0] data_q, skid_q;
    logic                      out_v_q, skid_v_q, infl_q;
    logic                      accept, rd_en, out_load, start;
    logic [1:0]                occ;
    always_comb begin
        start    = state_q == IDLE && store_enable;
        accept   = out_v_q && o_bus_ready;
        occ      = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, infl_q};
        // A full pipe may still issue when the head beat leaves this cycle
        rd_en    = state_q == STREAM && rd_left_q != '0 && (occ <= 2'd1 || (occ == 2'd2 && accept));
        out_load = (!out_v_q || accept) && (skid_v_q || infl_q);
        state_d  = start ? (store_count == '0 ? DONE : STREAM)
                 : (state_q == STREAM && accept && wr_left_q == COUNT_WIDTH'(1)) ? DONE
                 : state_q == DONE ? IDLE : state_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            sel_q       <= 1'b0;
            rd_left_q   <= '0;
            wr_left_q   <= '0;
            addr_q      <= '0;
            next_addr_q <= '0;
            data_q      <= '0;
            skid_q      <= '0;
            out_v_q     <= 1'b0;
            skid_v_q    <= 1'b0;
            infl_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                rd_addr_q   <= src_addr;
                sel_q       <= mem_sel;
                rd_left_q   <= store_count;
                wr_left_q   <= store_count;
                next_addr_q <= dst_addr;
            end
            if (rd_en) begin
                rd_addr_q <= rd_addr_q + MEM_ADDR_WIDTH'(1);
                rd_left_q <= rd_left_q - COUNT_WIDTH'(1);
            end
            infl_q <= rd_en;
            if (accept) wr_left_q <= wr_left_q - COUNT_WIDTH'(1);
            if (out_load) begin
                data_q      <= skid_v_q ? skid_q : mem_rd_data;
                addr_q      <= next_addr_q;
                next_addr_q <= next_addr_q + EXT_ADDR_WIDTH'(1);
            end
            out_v_q <= out_load || (out_v_q && !accept);
            if (infl_q && (skid_v_q || !out_load)) skid_q <= mem_rd_data;
            skid_v_q <= infl_q ? (skid_v_q || !out_load) : (skid_v_q && !out_load);
        end
    end
    assign busy            = state_q != IDLE;
    assign store_done      = state_q == DONE;
    assign mem_rd_en       = rd_en;
    assign mem_rd_addr     = rd_addr_q;
    assign mem_rd_sel      = sel_q;
    assign o_data_bus_port = data_q;
    assign o_feature_addr  = addr_q;
    assign o_feature_wr_en = out_v_q;
endmodule

// File: doc/o_feature_store.md
# o_feature_store

Output-feature writeback engine: the store-side counterpart of the input feature fetcher. On a decoded store command it reads `store_count` 128-bit lines from the selected on-chip output feature memory bank and writes them, in order, to consecutive external addresses over a valid/ready data bus, then pulses `store_done` so the top FSM can advance to the next instruction. It sits between the output feature memories and the external data bus port.

## Interface
Parameters:
- DATA_BUS_WIDTH, 128, width of one line/beat
- EXT_ADDR_WIDTH, 16, external address width
- MEM_ADDR_WIDTH, 8, on-chip memory line address width
- COUNT_WIDTH, 8, width of line count

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- store_enable  in  1  one-cycle start pulse from instruction decode
- src_addr  in  MEM_ADDR_WIDTH  first on-chip line
- dst_addr  in  EXT_ADDR_WIDTH  first external address
- mem_sel  in  1  output memory bank (0/1)
- store_count  in  COUNT_WIDTH  lines to move; 0 = empty command
- busy  out  1  command in progress
- store_done  out  1  one-cycle completion pulse
- mem_rd_en  out  1  on-chip read strobe
- mem_rd_addr  out  MEM_ADDR_WIDTH  on-chip read line
- mem_rd_sel  out  1  bank select, equals latched mem_sel
- mem_rd_data  in  DATA_BUS_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
- o_data_bus_port  out  DATA_BUS_WIDTH  write data
- o_feature_addr  out  EXT_ADDR_WIDTH  write address
- o_feature_wr_en  out  1  beat valid
- o_bus_ready  in  1  external sink ready

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE: store_enable=1 latches src_addr, dst_addr, mem_sel, store_count; go STREAM, or DONE if store_count==0.
- STREAM: issue reads at src, src+1, …; drive beats; leave for DONE in the cycle after the store_count-th beat is accepted.
- DONE: store_done=1 for one cycle; back to IDLE.
- busy=1 in STREAM and DONE.
- store_enable while busy: ignored entirely, no latching, no queuing.
- Beat accepted when o_feature_wr_en && o_bus_ready; o_feature_addr increments by 1 per accepted beat.
- Buffering: output register plus one skid entry (capacity 2). Track buffered (0..2) and inflight (0..1) reads.
- Issue read this cycle iff lines remain to read and (buffered+inflight ≤ 1, or buffered+inflight == 2 and a beat is accepted this cycle). Buffer never overflows; no read data is dropped.
- Returning data goes to the output register if empty (or being vacated), else to skid; skid drains to output register first. Order strictly preserved.
- Address arithmetic: on-chip address wraps modulo 2^MEM_ADDR_WIDTH, external modulo 2^EXT_ADDR_WIDTH; no error flag.
- While o_feature_wr_en=1 and o_bus_ready=0, o_data_bus_port and o_feature_addr hold stable.
- After the last beat o_feature_wr_en=0; data and address hold last values.

## Timing
- Reset values: busy, store_done, mem_rd_en, o_feature_wr_en = 0; mem_rd_addr, mem_rd_sel, o_data_bus_port, o_feature_addr = 0; FSM IDLE, counters 0.
- store_enable in cycle 0: busy=1 from cycle 1; first mem_rd_en in cycle 1.
- With o_bus_ready held 1 and N ≥ 1: mem_rd_en cycles 1..N; o_feature_wr_en cycles 3..N+2 (one beat/cycle); store_done cycle N+3; busy=0 from cycle N+4.
- store_count=0: store_done in cycle 1, busy=1 only in cycle 1, no reads or writes.
- Each ready-low cycle while a beat is pending delays completion by exactly one cycle.
- rst asserted mid-command: next cycle all outputs at reset values, no store_done pulse, command discarded.
- Next command accepted in the cycle busy is 0 (earliest cycle N+4).

## Test plan
- Basic: src=0x10, dst=0x0200, count=4, ready=1 -> reads 0x10..0x13 cycles 1–4, beats to 0x0200..0x0203 cycles 3–6, store_done cycle 7.
- Backpressure: count=8, ready toggling 1,0,0,1,0,… -> all 8 lines written in order to consecutive addresses, data/addr stable while stalled, never >2 buffered, store_done one cycle after 8th accept.
- Empty: count=0 -> store_done cycle 1, no mem_rd_en or o_feature_wr_en ever.
- Wrap: src=0xFE, dst=0xFFFF, count=4 -> reads FE,FF,00,01; writes FFFF,0000,0001,0002.
- Ignored start: second store_enable mid-command -> no effect; only first command's lines written, one store_done.
- Reset mid-op: rst at 3rd beat of count=8 -> outputs zero next cycle, no store_done; fresh count=2 command then completes normally.
